// File: rtl/blackjack_pkg.sv
// Shared BlackJack definitions: dealer FSM state encoding and legal card bounds.
package blackjack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEAL,
        EVAL,
        HIT,
        DONE
    } dealer_state_t;

    localparam int CARD_MIN = 1;
    localparam int CARD_MAX = 10;

endpackage : blackjack_pkg

// File: rtl/hand_slot_reg.sv
// Hand storage: slot array with clear, append-at-count, card count and the
// card legality filter. Illegal or over-capacity pushes leave state unchanged.
module hand_slot_reg
    import blackjack_pkg::*;
#(
    parameter int CARD_WL  = 4,
    parameter int CARD_NUM = 21,
    parameter int CNT_W    = $clog2(CARD_NUM) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [CARD_WL-1:0]           card,
    output logic                         card_legal,
    output logic [CARD_NUM*CARD_WL-1:0]  all_cards,
    output logic [CNT_W-1:0]             card_cnt
);

    logic [CARD_WL-1:0] slots [CARD_NUM];

    assign card_legal = (card >= CARD_WL'(CARD_MIN)) && (card <= CARD_WL'(CARD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CARD_NUM; k++) slots[k] <= '0;
            card_cnt <= '0;
        end else if (clear) begin
            for (int k = 0; k < CARD_NUM; k++) slots[k] <= '0;
            card_cnt <= '0;
        end else if (push && card_legal && (card_cnt < CNT_W'(CARD_NUM))) begin
            for (int k = 0; k < CARD_NUM; k++) begin
                if (CNT_W'(k) == card_cnt) slots[k] <= card;
            end
            card_cnt <= card_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < CARD_NUM; g++) begin : g_pack
        assign all_cards[g*CARD_WL +: CARD_WL] = slots[g];
    end

endmodule : hand_slot_reg

// File: rtl/dealer_hand_fsm.sv
// Dealer hand builder: deals two cards, then hits until the evaluator reports
// bust, stand or a full hand. Define DEALER_HIT_SOFT17_EN to hit on soft 17.
module dealer_hand_fsm
    import blackjack_pkg::*;
#(
    parameter int CARD_WL  = 4,
    parameter int CARD_NUM = 21,
    parameter int MAX_SUM  = 31,
    parameter int TARGET   = 21,
    parameter int STAND_TH = 17,
    localparam int SCORE_W = $clog2(MAX_SUM),
    localparam int CNT_W   = $clog2(CARD_NUM) + 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_card_valid,
    input  logic [CARD_WL-1:0]           i_card,
    output logic                         o_card_ready,
    output logic [CARD_NUM*CARD_WL-1:0]  o_all_cards,
    output logic [CNT_W-1:0]             o_card_cnt,
    input  logic [SCORE_W-1:0]           i_sum_hand,
    input  logic [SCORE_W-1:0]           i_score,
    input  logic                         i_usable_ace,
    input  logic                         i_bust,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [SCORE_W-1:0]           o_final_score,
    output logic                         o_final_bust
);

    // A threshold above the bust limit could never produce a stand.
    localparam int STAND_LIMIT = (STAND_TH < TARGET) ? STAND_TH : TARGET;

    dealer_state_t state;
    logic          card_take;
    logic          card_legal;
    logic          hand_clear;
    logic          stand;
    logic          hand_full;

    assign card_take  = i_card_valid && o_card_ready;
    assign hand_clear = i_start && ((state == IDLE) || (state == DONE));
    assign hand_full  = (o_card_cnt == CNT_W'(CARD_NUM));

`ifdef DEALER_HIT_SOFT17_EN
    assign stand = (i_sum_hand >= SCORE_W'(STAND_LIMIT)) &&
                   !((i_sum_hand == SCORE_W'(STAND_LIMIT)) && i_usable_ace);
`else
    logic unused_usable_ace;
    assign unused_usable_ace = i_usable_ace;
    assign stand = (i_sum_hand >= SCORE_W'(STAND_LIMIT));
`endif

    hand_slot_reg #(
        .CARD_WL  (CARD_WL),
        .CARD_NUM (CARD_NUM),
        .CNT_W    (CNT_W)
    ) u_slots (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (hand_clear),
        .push       (card_take),
        .card       (i_card),
        .card_legal (card_legal),
        .all_cards  (o_all_cards),
        .card_cnt   (o_card_cnt)
    );

    // Ready is registered and dropped on the accepting edge, so every card
    // taken in HIT is followed by exactly one EVAL cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_card_ready  <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_final_score <= '0;
            o_final_bust  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state         <= DEAL;
                        o_card_ready  <= 1'b1;
                        o_busy        <= 1'b1;
                        o_done        <= 1'b0;
                        o_final_score <= '0;
                        o_final_bust  <= 1'b0;
                    end
                end
                DEAL: begin
                    if (card_take && card_legal && (o_card_cnt == CNT_W'(1))) begin
                        state        <= EVAL;
                        o_card_ready <= 1'b0;
                    end
                end
                HIT: begin
                    if (card_take && card_legal) begin
                        state        <= EVAL;
                        o_card_ready <= 1'b0;
                    end
                end
                EVAL: begin
                    if (i_bust || stand || hand_full) begin
                        state         <= DONE;
                        o_busy        <= 1'b0;
                        o_done        <= 1'b1;
                        o_final_score <= i_score;
                        o_final_bust  <= i_bust;
                    end else begin
                        state        <= HIT;
                        o_card_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    o_card_ready <= 1'b0;
                    o_busy       <= 1'b0;
                    o_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule : dealer_hand_fsm

// File: doc/dealer_hand_fsm.md
# dealer_hand_fsm

Dealer-side hand builder for the BlackJack environment. It pulls cards from the card source over a valid/ready handshake and packs them into the flat hand bus that the hand evaluator consumes. It reads the evaluator's combinational results back and applies the dealer policy: hit below the stand threshold, otherwise stand. On bust it stops and latches the final score and bust flag for the episode controller.

## Interface
- CARD_WL, 4: card value width
- CARD_NUM, 21: hand capacity in card slots
- MAX_SUM, 31: sum range; score width is $clog2(MAX_SUM)
- TARGET, 21: bust limit (informational; bust comes from the evaluator)
- STAND_TH, 17: dealer stands when sum_hand >= STAND_TH
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle pulse that begins a new hand
- i_card_valid  in  1  card source has a card
- i_card  in  CARD_WL  card value; legal range 1..10
- o_card_ready  out  1  block will accept a card this cycle
- o_all_cards  out  CARD_NUM*CARD_WL  packed hand to the evaluator; slot k is at [k*CARD_WL +: CARD_WL]; empty slots are 0
- o_card_cnt  out  $clog2(CARD_NUM)+1  number of stored cards
- i_sum_hand  in  $clog2(MAX_SUM)  evaluator sum (ace counted as 11 when usable)
- i_score  in  $clog2(MAX_SUM)  evaluator score
- i_usable_ace  in  1  evaluator usable-ace flag
- i_bust  in  1  evaluator bust flag
- o_busy  out  1  high in DEAL, EVAL and HIT
- o_done  out  1  level, high in DONE
- o_final_score  out  $clog2(MAX_SUM)  score latched at hand end
- o_final_bust  out  1  bust flag latched at hand end

## Operation
- States: IDLE, DEAL, EVAL, HIT, DONE.
- IDLE/DONE: if i_start is high, clear every slot, o_card_cnt, o_final_* and o_done, then go to DEAL. Otherwise hold.
- i_start is ignored in DEAL, EVAL and HIT.
- Handshake: a card transfers when i_card_valid && o_card_ready.
- o_card_ready is high only in DEAL and HIT, and only while o_card_cnt < CARD_NUM.
- An accepted legal card goes into slot o_card_cnt, and o_card_cnt increments.
- An accepted card with value 0 or >10 is consumed and discarded. Slot and count are unchanged.
- DEAL: accept cards until o_card_cnt == 2, then go to EVAL.
- HIT: accept exactly one legal card, then go to EVAL.
- EVAL: sample the evaluator inputs, which reflect the current o_all_cards, and decide in priority order:
  - i_bust: go to DONE.
  - stand condition: go to DONE.
  - o_card_cnt == CARD_NUM: go to DONE (capacity stop).
  - otherwise: go to HIT.
- Stand condition: i_sum_hand >= STAND_TH, subject to the soft-17 rule in Configuration.
- On entry to DONE: o_final_score <= i_score and o_final_bust <= i_bust.
- Sum arithmetic lives in the evaluator only. This block does no card addition.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): state IDLE; all slots, o_card_cnt, o_final_score, o_final_bust = 0; o_card_ready, o_busy, o_done = 0.
- Reset asserted mid-hand aborts the hand immediately. No partial result is kept.
- i_start seen at edge N: state is DEAL and o_card_ready is high in cycle N+1.
- Card accepted at edge N: it is visible on o_all_cards and o_card_cnt in cycle N+1.
- o_card_ready is never high in EVAL, so each card accepted in HIT is followed by exactly one EVAL cycle.
- Per hit: accept at edge N, EVAL in cycle N+1, o_card_ready high again in cycle N+2 (or o_done high in N+2).
- DEAL accepts back-to-back cards with no bubble.

## Configuration
- DEALER_HIT_SOFT17_EN defined: the stand condition is (i_sum_hand >= STAND_TH) && !(i_sum_hand == STAND_TH && i_usable_ace). The dealer hits on soft 17.
- Not defined: the stand condition is i_sum_hand >= STAND_TH. The dealer stands on all 17s.

## Structure
- Shared package (blackjack_pkg): state enum and the card legality bounds CARD_MIN=1, CARD_MAX=10.
- One natural sub-module: hand_slot_reg. It holds the slot array with clear, append-at-count and count output, plus the legality filter.
- The evaluator is instantiated by the parent alongside this block, not inside it.

## Test plan
- Cards 10, 7 → stand after the EVAL that follows the 2nd card; o_done=1, o_final_score=17, o_final_bust=0, o_card_cnt=2.
- Cards 1, 6, then 10 offered:
  - without the macro: stand with score 17 and cnt 2; the third card is never accepted.
  - with DEALER_HIT_SOFT17_EN: hit, take the 10, hard 17, stand; score 17, cnt 3.
- Cards 10, 5, 9 → bust after the 3rd card; o_final_bust=1, o_final_score=0.
- Cards 0, 12, 10, 8 → the first two are consumed and discarded; stand at 18 with cnt 2; slots 2..20 remain 0.
- CARD_NUM=3, cards 1, 1, 1 → capacity stop: cnt 3, sum 13, o_done=1, o_card_ready=0.
- i_start during HIT is ignored.
- i_rst_n pulsed low mid-HIT → outputs return to reset values immediately; a new i_start then deals normally.
